spi_ram_ctrl: RTL
=================

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: RAM address/data width. rx_data is ADDR_W+2 bits; tx_data is ADDR_W bits.
REQ-002 Port clk, in, 1: single clock; all state updates on its rising edge; also serves as SPI SCK.
REQ-003 Port rst, in, 1: reset, asynchronous and active-high.
REQ-004 Port ss_n, in, 1: SPI slave select, active-low; frame boundary.
REQ-005 Port mosi, in, 1: serial input, MSB first.
REQ-006 Port miso, out, 1: serial output to master, MSB first.
REQ-007 Port rx_data, out, ADDR_W+2: word to RAM; [ADDR_W+1:ADDR_W] = 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-008 Port rx_valid, out, 1: one-cycle strobe; rx_data is valid.
REQ-009 Port tx_data, in, ADDR_W: read data from RAM.
REQ-010 Port tx_valid, in, 1: RAM strobe; tx_data is valid this cycle.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD when ss_n=0; otherwise stay in IDLE.
REQ-013 CHK_CMD samples mosi (command bit). mosi=0 -> WRITE. mosi=1 and rd_addr_seen=0 -> READ_ADD. mosi=1 and rd_addr_seen=1 -> READ_DATA.
REQ-014 WRITE, READ_ADD and READ_DATA each shift ADDR_W+2 mosi bits, MSB first, into a shift register, one bit per cycle.
REQ-015 The cycle after the last bit: rx_data is loaded and rx_valid=1 for exactly one cycle.
  - Latency: rx_valid asserts ADDR_W+3 cycles after the CHK_CMD cycle (ADDR_W=8 -> 11).
REQ-016 rx_valid in READ_ADD sets rd_addr_seen=1; rx_valid in READ_DATA clears it.
  - rd_addr_seen persists across frames; it is cleared only by rst.
REQ-017 After rx_valid in WRITE or READ_ADD: remain in that state and ignore mosi until ss_n=1.
REQ-018 After rx_valid in READ_DATA: wait for tx_valid.
  - On tx_valid=1: latch tx_data.
  - Starting the next cycle: drive ADDR_W bits on miso, MSB first, one per cycle.
  - Then hold miso=0 until ss_n=1.
REQ-019 Any tx_valid arriving outside the READ_DATA wait window SHALL be ignored.
REQ-020 ss_n=1 in any state -> IDLE on the next edge.
  - Bit counter and shift register are cleared.
  - miso=0.
  - A partial frame produces no rx_valid.
REQ-021 ss_n rising in the same cycle the last bit would be sampled: the frame is aborted and rx_valid is not asserted.
REQ-022 Outside miso transmission, miso=0.

Reset
REQ-023 While rst=1, asynchronously:
  - state=IDLE
  - miso=0, rx_valid=0, rx_data=0
  - rd_addr_seen=0
  - counters cleared
  - frame_err=0 (when present)
REQ-024 rst asserted mid-frame aborts the frame; no strobe is issued on release.

Configuration
REQ-025 Macro SPI_FRAME_ERR_EN, when defined, adds output frame_err (1 bit), set when ss_n rises before a frame completes:
  - in CHK_CMD,
  - mid-shift, or
  - mid-miso transmission.
  - frame_err holds until the next ss_n falling edge or rst.
REQ-026 Without SPI_FRAME_ERR_EN, the frame_err port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Package spi_ram_pkg SHALL hold:
  - the state enum;
  - command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - default ADDR_W.
REQ-028 Single module with one FSM, one shift register, one bit counter, one tx latch. No sub-module is required.

Verification
REQ-029 Write-address frame: ss_n=0, mosi stream 0 then 00_1111_1111 -> rx_valid one cycle, rx_data=10'h0FF, rd_addr_seen unchanged.
REQ-030 Read-address then read-data: frame 1 '1'+10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1. Frame 2 '1'+11_0000_0000, with tx_valid and tx_data=8'hA5 two cycles after rx_valid -> miso=1,0,1,0,0,1,0,1 on 8 consecutive cycles, rd_addr_seen=0.
REQ-031 Abort: ss_n rises after 5 data bits of a write frame -> no rx_valid, state IDLE next cycle; frame_err=1 if SPI_FRAME_ERR_EN is defined.
REQ-032 Read-data with no prior read-address (after rst): command 1 -> READ_ADD path taken; rx_data[9:8] is whatever was shifted; no miso activity.
REQ-033 rst asserted mid-miso (after 3 bits) -> miso=0 and state IDLE immediately; new write frame after release produces correct rx_valid.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM slave controller: FSM states,
// command encodings carried in rx_data[ADDR_W+1:ADDR_W], and default width.
package spi_ram_pkg;

  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/spi_ram_ctrl.sv
// SPI slave that frames mosi into RAM words and streams RAM read data on miso.
// Optional frame_err output is enabled by defining SPI_FRAME_ERR_EN.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [ADDR_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int FRAME_W = ADDR_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(ADDR_W);

  state_e              state;
  logic [FRAME_W-2:0]  shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   tx_reg;
  logic                rx_done;
  logic                tx_wait;
  logic                tx_busy;
  logic                rd_addr_seen;

  // bit_cnt counts received bits, then is reused to count transmitted bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      tx_reg       <= '0;
      rx_done      <= 1'b0;
      tx_wait      <= 1'b0;
      tx_busy      <= 1'b0;
      rd_addr_seen <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        state     <= IDLE;
        shift_reg <= '0;
        bit_cnt   <= '0;
        rx_done   <= 1'b0;
        tx_wait   <= 1'b0;
        tx_busy   <= 1'b0;
        miso      <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            if (!mosi)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!rx_done) begin
              shift_reg <= {shift_reg[FRAME_W-3:0], mosi};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= {shift_reg, mosi};
                rx_valid <= 1'b1;
                rx_done  <= 1'b1;
                bit_cnt  <= '0;
                if (state == READ_ADD)
                  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_seen <= 1'b0;
                  tx_wait      <= 1'b1;
                end
              end
            end else if (tx_wait) begin
              if (tx_valid) begin
                tx_wait <= 1'b0;
                tx_busy <= 1'b1;
                miso    <= tx_data[ADDR_W-1];
                tx_reg  <= {tx_data[ADDR_W-2:0], 1'b0};
                bit_cnt <= CNT_W'(1);
              end
            end else if (tx_busy) begin
              if (bit_cnt == LAST_TX) begin
                miso    <= 1'b0;
                tx_busy <= 1'b0;
              end else begin
                miso    <= tx_reg[ADDR_W-1];
                tx_reg  <= {tx_reg[ADDR_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic shifting;
  assign shifting = (state == WRITE || state == READ_ADD || state == READ_DATA) && !rx_done;

  // Sticky until the master starts the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_err <= 1'b0;
    else if (state == IDLE && !ss_n)
      frame_err <= 1'b0;
    else if (ss_n && (state == CHK_CMD || shifting || tx_busy))
      frame_err <= 1'b1;
  end
`endif

endmodule
